// File: rtl/align_pkg.sv
// Shared encodings for the alignment datapath: direction codes written by the
// scoring array, edit-operation codes, and the traceback FSM state type.
package align_pkg;

    localparam logic [2:0] DIR_STOP   = 3'b000;
    localparam logic [2:0] DIR_DIAG_M = 3'b001;
    localparam logic [2:0] DIR_DIAG_X = 3'b010;
    localparam logic [2:0] DIR_UP     = 3'b011;
    localparam logic [2:0] DIR_LEFT   = 3'b100;

    localparam logic [1:0] OP_MATCH    = 2'b00;
    localparam logic [1:0] OP_MISMATCH = 2'b01;
    localparam logic [1:0] OP_INS      = 2'b10;
    localparam logic [1:0] OP_DEL      = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_EMIT   = 3'd3,
        S_FINISH = 3'd4
    } state_t;

endpackage

// File: rtl/tb_step_decode.sv
// Decodes one direction code at cell (row, col) into the emitted operation and
// the predecessor cell; flags STOP and any illegal code or off-matrix move.
module tb_step_decode
    import align_pkg::*;
#(
    parameter int ROW_W = 5,
    parameter int COL_W = 5
) (
    input  logic [2:0]       code,
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    output logic [1:0]       op,
    output logic [ROW_W-1:0] next_row,
    output logic [COL_W-1:0] next_col,
    output logic             stop,
    output logic             illegal
);

    always_comb begin
        op       = OP_MATCH;
        next_row = row;
        next_col = col;
        stop     = 1'b0;
        illegal  = 1'b0;
        case (code)
            DIR_STOP: stop = 1'b1;
            DIR_DIAG_M, DIR_DIAG_X: begin
                op = (code == DIR_DIAG_M) ? OP_MATCH : OP_MISMATCH;
                if (row == '0 || col == '0) begin
                    illegal = 1'b1;
                end else begin
                    next_row = row - 1'b1;
                    next_col = col - 1'b1;
                end
            end
            DIR_UP: begin
                op = OP_INS;
                if (row == '0) illegal = 1'b1;
                else           next_row = row - 1'b1;
            end
            DIR_LEFT: begin
                op = OP_DEL;
                if (col == '0) illegal = 1'b1;
                else           next_col = col - 1'b1;
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/align_traceback.sv
// Walks the direction memory backward from an end cell and streams the
// alignment as edit operations over a valid/ready interface.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | read strobe for the current cell is out (or (0,0) reached)
// WAIT   | direction code arrives; decode it
// EMIT   | operation held on op_valid until op_ready
// FINISH | done pulse (err if aborted), busy drops
module align_traceback
    import align_pkg::*;
#(
    parameter int QLEN  = 16,
    parameter int SLEN  = 16,
    parameter int ROW_W = $clog2(QLEN + 1),
    parameter int COL_W = $clog2(SLEN + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [ROW_W-1:0]       start_row,
    input  logic [COL_W-1:0]       start_col,
    output logic                   mem_rd_en,
    output logic [ROW_W+COL_W-1:0] mem_rd_addr,
    input  logic [2:0]             mem_rd_data,
    output logic                   op_valid,
    input  logic                   op_ready,
    output logic [1:0]             op,
    output logic [ROW_W-1:0]       op_row,
    output logic [COL_W-1:0]       op_col,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic [ROW_W+COL_W-1:0] path_len
);

    localparam int                   PW      = ROW_W + COL_W;
    localparam logic [ROW_W-1:0]     ROW_MAX = ROW_W'(QLEN);
    localparam logic [COL_W-1:0]     COL_MAX = COL_W'(SLEN);
    localparam logic [PW-1:0]        LEN_MAX = PW'(QLEN + SLEN);

    state_t           state;
    logic [ROW_W-1:0] row;
    logic [COL_W-1:0] col;

    logic [1:0]       dec_op;
    logic [ROW_W-1:0] dec_row;
    logic [COL_W-1:0] dec_col;
    logic             dec_stop;
    logic             dec_illegal;
    logic [PW-1:0]    len_next;

    tb_step_decode #(
        .ROW_W (ROW_W),
        .COL_W (COL_W)
    ) u_step_decode (
        .code     (mem_rd_data),
        .row      (row),
        .col      (col),
        .op       (dec_op),
        .next_row (dec_row),
        .next_col (dec_col),
        .stop     (dec_stop),
        .illegal  (dec_illegal)
    );

    assign len_next = path_len + 1'b1;

    // row/col advance to the predecessor cell when the op is loaded, so the
    // read for the next cell can be launched on the handshake edge itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            row         <= '0;
            col         <= '0;
            mem_rd_en   <= 1'b0;
            mem_rd_addr <= '0;
            op_valid    <= 1'b0;
            op          <= OP_MATCH;
            op_row      <= '0;
            op_col      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            path_len    <= '0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            mem_rd_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        busy     <= 1'b1;
                        path_len <= '0;
                        if (start_row <= ROW_MAX && start_col <= COL_MAX) begin
                            row         <= start_row;
                            col         <= start_col;
                            mem_rd_en   <= |{start_row, start_col};
                            mem_rd_addr <= {start_row, start_col};
                            state       <= S_FETCH;
                        end else begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= S_FINISH;
                        end
                    end
                end
                S_FETCH: begin
                    if (row == '0 && col == '0) begin
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (dec_illegal) begin
                        done  <= 1'b1;
                        err   <= 1'b1;
                        state <= S_FINISH;
                    end else if (dec_stop) begin
                        done  <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        op       <= dec_op;
                        op_row   <= row;
                        op_col   <= col;
                        op_valid <= 1'b1;
                        row      <= dec_row;
                        col      <= dec_col;
                        state    <= S_EMIT;
                    end
                end
                S_EMIT: begin
                    if (op_ready) begin
                        op_valid <= 1'b0;
                        path_len <= len_next;
                        if (len_next == LEN_MAX) begin
                            done  <= 1'b1;
                            err   <= 1'b1;
                            state <= S_FINISH;
                        end else begin
                            mem_rd_en   <= |{row, col};
                            mem_rd_addr <= {row, col};
                            state       <= S_FETCH;
                        end
                    end
                end
                S_FINISH: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_align_traceback.sv
// Directed bench for align_traceback: a direction-memory model, expected
// ops/done results queued per run and popped by a concurrent monitor.
module tb_align_traceback;
    import align_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [2:0] start_row;
    logic [2:0] start_col;
    logic       mem_rd_en;
    logic [5:0] mem_rd_addr;
    logic [2:0] mem_rd_data = 3'b000;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] op;
    logic [2:0] op_row;
    logic [2:0] op_col;
    logic       busy;
    logic       done;
    logic       err;
    logic [5:0] path_len;

    logic [2:0] dir_mem [0:63];
    logic [7:0] exp_ops [$];
    logic [6:0] exp_done [$];
    int n_cmp = 0;
    int n_mis = 0;

    logic       mon_stalled;
    logic [7:0] mon_held;
    logic [7:0] mon_e;
    logic [6:0] mon_d;

    always #5 clk = ~clk;

    always @(posedge clk) if (mem_rd_en) mem_rd_data <= dir_mem[mem_rd_addr];

    align_traceback #(.QLEN(4), .SLEN(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_row   (start_row),
        .start_col   (start_col),
        .mem_rd_en   (mem_rd_en),
        .mem_rd_addr (mem_rd_addr),
        .mem_rd_data (mem_rd_data),
        .op_valid    (op_valid),
        .op_ready    (op_ready),
        .op          (op),
        .op_row      (op_row),
        .op_col      (op_col),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .path_len    (path_len)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int adr(input int r, input int c);
        return r * 8 + c;
    endfunction

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) dir_mem[i] = 3'b111;
    endtask

    task automatic push_op(input logic [1:0] o, input int r, input int c);
        exp_ops.push_back({o, 3'(r), 3'(c)});
    endtask

    task automatic push_done(input logic e, input int len);
        exp_done.push_back({e, 6'(len)});
    endtask

    task automatic run_trace(input int r, input int c, input int stall, input bit chk_lat,
                             input int exp_done_k, input bit no_read, input bit poke);
        int k = 0;
        int low = 0;
        bit seen = 0, rd_seen = 0, release_ready = 0, hs_seen = 0, chk_next_rd = 0, got_done = 0;
        @(posedge clk); #1;
        start = 1'b1; start_row = 3'(r); start_col = 3'(c); op_ready = (stall == 0);
        @(posedge clk); #1;
        start = 1'b0;
        while (!got_done && k < 400) begin
            @(negedge clk);
            k++;
            if (mem_rd_en) rd_seen = 1;
            if (k == 1 && chk_lat) chk("rd_en_first_cycle", mem_rd_en, 1);
            if (chk_next_rd) begin
                chk("rd_en_after_handshake", mem_rd_en, 1);
                chk_next_rd = 0;
            end
            if (op_valid && !seen) begin
                seen = 1;
                if (chk_lat) chk("op_valid_latency", k, 3);
            end
            if (stall > 0 && op_valid && op_ready && !hs_seen) begin
                hs_seen = 1;
                chk("rd_en_at_handshake", mem_rd_en, 0);
                chk_next_rd = 1;
            end
            if (stall > 0 && op_valid && !op_ready) begin
                low++;
                if (low == stall) release_ready = 1;
            end
            if (done) begin
                got_done = 1;
                if (exp_done_k > 0) chk("done_latency", k, exp_done_k);
                chk("busy_at_done", busy, 1);
            end
            @(posedge clk); #1;
            if (release_ready) op_ready = 1'b1;
            if (poke && k == 2) begin
                start = 1'b1; start_row = 3'd5; start_col = 3'd0;
            end else if (k == 3) begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (!got_done) begin
            n_cmp++; n_mis++;
            $display("FAIL done_timeout: no done within %0d cycles", k);
        end else begin
            @(negedge clk);
            chk("busy_after_done", busy, 0);
            chk("done_one_cycle", done, 0);
        end
        if (no_read) chk("no_mem_read", rd_seen, 0);
        op_ready = 1'b1;
    endtask

    task automatic load_diag();
        clear_mem();
        dir_mem[adr(3,3)] = DIR_DIAG_M;
        dir_mem[adr(2,2)] = DIR_DIAG_M;
        dir_mem[adr(1,1)] = DIR_DIAG_X;
        dir_mem[adr(0,0)] = DIR_STOP;
    endtask

    task automatic push_diag();
        push_op(OP_MATCH, 3, 3);
        push_op(OP_MATCH, 2, 2);
        push_op(OP_MISMATCH, 1, 1);
        push_done(1'b0, 3);
    endtask

    task automatic load_updiag();
        clear_mem();
        dir_mem[adr(2,2)] = DIR_UP;
        dir_mem[adr(1,2)] = DIR_LEFT;
        dir_mem[adr(1,1)] = DIR_DIAG_M;
    endtask

    task automatic push_updiag();
        push_op(OP_INS, 2, 2);
        push_op(OP_DEL, 1, 2);
        push_op(OP_MATCH, 1, 1);
        push_done(1'b0, 3);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_row = '0; start_col = '0; op_ready = 1'b1;
        mon_stalled = 1'b0; mon_held = '0;
        clear_mem();

        fork
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    mon_stalled = 1'b0;
                end else begin
                    if (mon_stalled) begin
                        chk("stall_valid_held", op_valid, 1);
                        chk("stall_op_stable", {op, op_row, op_col}, mon_held);
                    end
                    if (op_valid && op_ready) begin
                        if (exp_ops.size() == 0) begin
                            n_cmp++; n_mis++;
                            $display("FAIL unexpected_op: got op %0d at (%0d,%0d), none expected", op, op_row, op_col);
                        end else begin
                            mon_e = exp_ops.pop_front();
                            chk("op_row_col", {op, op_row, op_col}, mon_e);
                        end
                    end
                    mon_stalled = op_valid && !op_ready;
                    mon_held = {op, op_row, op_col};
                    if (done) begin
                        if (exp_done.size() == 0) begin
                            n_cmp++; n_mis++;
                            $display("FAIL unexpected_done: err %0d path_len %0d", err, path_len);
                        end else begin
                            mon_d = exp_done.pop_front();
                            chk("done_err", err, mon_d[6]);
                            chk("done_path_len", path_len, mon_d[5:0]);
                        end
                    end else begin
                        chk("err_outside_done", err, 0);
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_op_valid", op_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_path_len", path_len, 0);
        chk("rst_mem_rd_en", mem_rd_en, 0);
        chk("rst_mem_rd_addr", mem_rd_addr, 0);
        rst_n = 1'b1;

        // pure diagonal from (3,3)
        load_diag(); push_diag();
        run_trace(3, 3, 0, 1, -1, 0, 0);

        // UP, LEFT, DIAG from (2,2), with an ignored start poke while busy
        load_updiag(); push_updiag();
        run_trace(2, 2, 0, 0, -1, 0, 1);

        // same path, op_ready low for 5 cycles on the first op
        load_updiag(); push_updiag();
        run_trace(2, 2, 5, 0, -1, 0, 0);

        // illegal code at the start cell
        clear_mem(); dir_mem[adr(2,3)] = 3'b110; push_done(1'b1, 0);
        run_trace(2, 3, 0, 0, -1, 0, 0);

        // UP at row 0
        clear_mem(); dir_mem[adr(0,2)] = DIR_UP; push_done(1'b1, 0);
        run_trace(0, 2, 0, 0, -1, 0, 0);

        // LEFT at col 0
        clear_mem(); dir_mem[adr(3,0)] = DIR_LEFT; push_done(1'b1, 0);
        run_trace(3, 0, 0, 0, -1, 0, 0);

        // out-of-range start row
        clear_mem(); push_done(1'b1, 0);
        run_trace(5, 1, 0, 0, 1, 1, 0);

        // longest path trips the QLEN+SLEN guard on its last handshake
        clear_mem();
        dir_mem[adr(4,4)] = DIR_UP;   dir_mem[adr(3,4)] = DIR_UP;
        dir_mem[adr(2,4)] = DIR_UP;   dir_mem[adr(1,4)] = DIR_UP;
        dir_mem[adr(0,4)] = DIR_LEFT; dir_mem[adr(0,3)] = DIR_LEFT;
        dir_mem[adr(0,2)] = DIR_LEFT; dir_mem[adr(0,1)] = DIR_LEFT;
        push_op(OP_INS, 4, 4); push_op(OP_INS, 3, 4);
        push_op(OP_INS, 2, 4); push_op(OP_INS, 1, 4);
        push_op(OP_DEL, 0, 4); push_op(OP_DEL, 0, 3);
        push_op(OP_DEL, 0, 2); push_op(OP_DEL, 0, 1);
        push_done(1'b1, 8);
        run_trace(4, 4, 0, 0, -1, 0, 0);

        // reset while an op is waiting in EMIT
        load_diag();
        @(posedge clk); #1;
        op_ready = 1'b0; start = 1'b1; start_row = 3'd3; start_col = 3'd3;
        @(posedge clk); #1;
        start = 1'b0;
        begin
            int k = 0;
            while (!op_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
            chk("pre_reset_op_valid", op_valid, 1);
        end
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_op_valid", op_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_op_row", op_row, 0);
        chk("mid_rst_done", done, 0);
        op_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);

        load_diag(); push_diag();
        run_trace(3, 3, 0, 1, -1, 0, 0);

        repeat (4) @(posedge clk);
        chk("ops_left_in_queue", exp_ops.size(), 0);
        chk("dones_left_in_queue", exp_done.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
